// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master: FSM states, bit-slot quarters
// and the bus-level meaning of a sampled ACK bit.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_C,
        ADDR,
        ACK_ADDR,
        WRITE_DATA,
        ACK_DATA,
        READ_DATA,
        MASTER_NACK,
        STOP_C
    } master_state_t;

    typedef enum logic [1:0] {
        Q0,
        Q1,
        Q2,
        Q3
    } quarter_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_quarter_gen.sv
// Divides the system clock into SCL quarter-periods; a bit slot is four quarters.
// Held cleared while disabled so every transaction starts on a fresh slot.
module i2c_quarter_gen
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    output quarter_t quarter,
    output logic     qtick,
    output logic     slot_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    quarter_t         quarter_q, quarter_d;

    assign qtick    = en && (div_cnt_q == DIV_LAST);
    assign slot_end = qtick && (quarter_q == Q3);
    assign quarter  = quarter_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        quarter_d = quarter_q;
        if (!en) begin
            div_cnt_d = '0;
            quarter_d = Q0;
        end else if (qtick) begin
            div_cnt_d = '0;
            quarter_d = quarter_t'(quarter_q + 2'd1);
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            quarter_q <= Q0;
        end else begin
            div_cnt_q <= div_cnt_d;
            quarter_q <= quarter_d;
        end
    end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-byte I2C master: START, address+R/W, ACK check, one data byte, STOP.
// SCL and SDA are open-drain: each line is either pulled low or released.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire                   scl,
    inout  wire                   sda,
    input  logic                  start,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] slave_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_error
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    master_state_t         state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH:0]   addr_sr_q, addr_sr_d;
    logic [DATA_WIDTH-1:0] wdata_sr_q, wdata_sr_d;
    logic [DATA_WIDTH-1:0] rdata_sr_q, rdata_sr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rw_q, rw_d;
    logic                  ack_error_q, ack_error_d;
    logic                  done_q, done_d;
    logic                  sda_sample_q, sda_sample_d;

    quarter_t quarter;
    logic     qtick, slot_end, sample_tick, accept, sda_in, qgen_en;
    logic     scl_low, sda_low;

    assign qgen_en = (state_q != IDLE);

    i2c_quarter_gen #(.CLK_DIV(CLK_DIV)) u_quarter_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (qgen_en),
        .quarter  (quarter),
        .qtick    (qtick),
        .slot_end (slot_end)
    );

    // Done cycle is still IDLE, so it must be excluded to ignore a start there
    assign accept      = (state_q == IDLE) && start && !done_q;
    assign sample_tick = qtick && (quarter == Q2);
    assign sda_in      = sda;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        addr_sr_d    = addr_sr_q;
        wdata_sr_d   = wdata_sr_q;
        rdata_sr_d   = rdata_sr_q;
        data_out_d   = data_out_q;
        rw_d         = rw_q;
        ack_error_d  = ack_error_q;
        sda_sample_d = sda_sample_q;
        done_d       = 1'b0;

        if (accept) begin
            state_d     = START_C;
            rw_d        = rw;
            addr_sr_d   = {slave_addr, rw};
            wdata_sr_d  = data_in;
            ack_error_d = 1'b0;
        end

        if (sample_tick) begin
            sda_sample_d = sda_in;
            if (state_q == READ_DATA) begin
                rdata_sr_d = {rdata_sr_q[DATA_WIDTH-2:0], sda_in};
            end
        end

        // Slot counters are reloaded on every state entry and never wrap
        if (slot_end) begin
            bit_cnt_d = '0;
            case (state_q)
                START_C: begin
                    state_d   = ADDR;
                    bit_cnt_d = ADDR_LAST;
                end
                ADDR: begin
                    addr_sr_d = addr_sr_q << 1;
                    if (bit_cnt_q == '0) state_d = ACK_ADDR;
                    else                 bit_cnt_d = bit_cnt_q - 1'b1;
                end
                ACK_ADDR: begin
                    if (sda_sample_q == I2C_NACK) begin
                        ack_error_d = 1'b1;
                        state_d     = STOP_C;
                    end else begin
                        state_d   = rw_q ? READ_DATA : WRITE_DATA;
                        bit_cnt_d = DATA_LAST;
                    end
                end
                WRITE_DATA: begin
                    wdata_sr_d = wdata_sr_q << 1;
                    if (bit_cnt_q == '0) state_d = ACK_DATA;
                    else                 bit_cnt_d = bit_cnt_q - 1'b1;
                end
                ACK_DATA: begin
                    if (sda_sample_q == I2C_NACK) ack_error_d = 1'b1;
                    state_d = STOP_C;
                end
                READ_DATA: begin
                    if (bit_cnt_q == '0) begin
                        state_d    = MASTER_NACK;
                        data_out_d = rdata_sr_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                    end
                end
                MASTER_NACK: state_d = STOP_C;
                STOP_C: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        scl_low = 1'b0;
        sda_low = 1'b0;
        case (state_q)
            IDLE: begin
                scl_low = 1'b0;
                sda_low = 1'b0;
            end
            START_C: sda_low = (quarter == Q2) || (quarter == Q3);
            STOP_C: begin
                scl_low = (quarter == Q0);
                sda_low = (quarter == Q0) || (quarter == Q1);
            end
            default: begin
                scl_low = (quarter == Q0) || (quarter == Q1);
                if (state_q == ADDR)       sda_low = !addr_sr_q[ADDR_WIDTH];
                if (state_q == WRITE_DATA) sda_low = !wdata_sr_q[DATA_WIDTH-1];
            end
        endcase
    end

    assign scl = scl_low ? 1'b0 : 1'bz;
    assign sda = sda_low ? 1'b0 : 1'bz;

    assign data_out  = data_out_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ack_error = ack_error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            addr_sr_q    <= '0;
            wdata_sr_q   <= '0;
            rdata_sr_q   <= '0;
            data_out_q   <= '0;
            rw_q         <= 1'b0;
            ack_error_q  <= 1'b0;
            done_q       <= 1'b0;
            sda_sample_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_sr_q    <= addr_sr_d;
            wdata_sr_q   <= wdata_sr_d;
            rdata_sr_q   <= rdata_sr_d;
            data_out_q   <= data_out_d;
            rw_q         <= rw_d;
            ack_error_q  <= ack_error_d;
            done_q       <= done_d;
            sda_sample_q <= sda_sample_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench for i2c_master_controller with a bus-level slave model at
// address 7'h2A, plus a CLK_DIV=2 instance on its own bus for waveform timing.
module tb_i2c_master_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] slave_addr = 7'h00;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       busy, done, ack_error;
    wire        scl, sda;

    logic       start2 = 1'b0;
    logic       rw2 = 1'b0;
    logic [6:0] slave_addr2 = 7'h11;
    logic [7:0] data_in2 = 8'hFF;
    logic [7:0] data_out2;
    logic       busy2, done2, ack_error2;
    wire        scl2, sda2;

    int pass_cnt = 0;
    int total_cnt = 0;

    pullup (scl);
    pullup (sda);
    pullup (scl2);
    pullup (sda2);

    always #5 clk = ~clk;

    i2c_master_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl),
        .sda        (sda),
        .start      (start),
        .rw         (rw),
        .slave_addr (slave_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .ack_error  (ack_error)
    );

    i2c_master_controller #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CLK_DIV(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .scl        (scl2),
        .sda        (sda2),
        .start      (start2),
        .rw         (rw2),
        .slave_addr (slave_addr2),
        .data_in    (data_in2),
        .data_out   (data_out2),
        .busy       (busy2),
        .done       (done2),
        .ack_error  (ack_error2)
    );

    wire scl_b  = (scl  !== 1'b0);
    wire sda_b  = (sda  !== 1'b0);
    wire scl2_b = (scl2 !== 1'b0);
    wire sda2_b = (sda2 !== 1'b0);

    // Slave at 7'h2A: reacts to SCL edges seen on the falling system clock
    localparam logic [6:0] SLAVE_ADDR = 7'h2A;
    logic [7:0]  slave_rdata = 8'h3C;
    logic        s_prev_scl = 1'b1, s_prev_sda = 1'b1;
    logic        s_active = 1'b0, s_drive = 1'b0;
    logic [7:0]  s_addr_rw = 8'h00, s_rx = 8'h00;
    int          s_rise = 0;
    logic [31:0] bus_bits = 32'h0;
    int          bus_nbits = 0, start_cnt = 0, stop_cnt = 0;
    wire         s_match = (s_addr_rw[7:1] == SLAVE_ADDR);
    wire         s_read  = s_addr_rw[0];

    assign sda = s_drive ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        s_prev_scl <= scl_b;
        s_prev_sda <= sda_b;
        if (s_prev_scl && scl_b && s_prev_sda && !sda_b) begin
            s_active  <= 1'b1;
            s_rise    <= 0;
            s_drive   <= 1'b0;
            bus_bits  <= 32'h0;
            bus_nbits <= 0;
            start_cnt <= start_cnt + 1;
        end else if (s_prev_scl && scl_b && !s_prev_sda && sda_b) begin
            s_active <= 1'b0;
            s_drive  <= 1'b0;
            stop_cnt <= stop_cnt + 1;
        end else if (!s_prev_scl && scl_b) begin
            bus_bits  <= {bus_bits[30:0], sda_b};
            bus_nbits <= bus_nbits + 1;
            if (s_active) begin
                s_rise <= s_rise + 1;
                if (s_rise < 8) s_addr_rw <= {s_addr_rw[6:0], sda_b};
                else if (s_rise >= 9 && s_rise < 17) s_rx <= {s_rx[6:0], sda_b};
            end
        end else if (s_prev_scl && !scl_b && s_active) begin
            if (s_rise == 8)
                s_drive <= s_match;
            else if (s_rise >= 9 && s_rise <= 16 && s_match && s_read)
                s_drive <= !slave_rdata[16 - s_rise];
            else if (s_rise == 17)
                s_drive <= s_match && !s_read;
            else
                s_drive <= 1'b0;
        end
    end

    // Waveform monitor for the CLK_DIV=2 instance
    logic p_scl2 = 1'b1, p_sda2 = 1'b1, seen_rise2 = 1'b0, seen_fall2 = 1'b0;
    int   run2 = 0, start2_cnt = 0, stop2_cnt = 0;
    int   hi_ok = 0, hi_bad = 0, lo4 = 0, lo_other = 0;

    always @(negedge clk) begin
        p_scl2 <= scl2_b;
        p_sda2 <= sda2_b;
        run2   <= run2 + 1;
        if (p_scl2 && scl2_b && p_sda2 && !sda2_b) start2_cnt <= start2_cnt + 1;
        if (p_scl2 && scl2_b && !p_sda2 && sda2_b) stop2_cnt <= stop2_cnt + 1;
        if (p_scl2 && !scl2_b) begin
            if (seen_rise2) begin
                if (run2 == 4) hi_ok <= hi_ok + 1;
                else           hi_bad <= hi_bad + 1;
            end
            seen_fall2 <= 1'b1;
            run2       <= 1;
        end
        if (!p_scl2 && scl2_b) begin
            if (seen_fall2) begin
                if (run2 == 4) lo4 <= lo4 + 1;
                else           lo_other <= lo_other + 1;
            end
            seen_rise2 <= 1'b1;
            run2       <= 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Runs one transaction on dut and checks the handshake around it
    task automatic applyStimulus(input string tag, input logic r, input logic [6:0] a,
                                 input logic [7:0] d, input bit hold_start,
                                 input int exp_lat, output logic err_at_accept);
        int lat;
        int drops;
        @(negedge clk);
        rw = r;
        slave_addr = a;
        data_in = d;
        start = 1'b1;
        @(posedge clk);
        lat = 0;
        drops = 0;
        @(negedge clk);
        err_at_accept = ack_error;
        if (!hold_start) start = 1'b0;
        while (done !== 1'b1 && lat < 2000) begin
            if (busy !== 1'b1) drops++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_busy_gaps"}, drops, 0);
        checkOutput({tag, "_busy_at_done"}, {31'b0, busy}, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_done_pulse"}, {31'b0, done}, 0);
        checkOutput({tag, "_idle_after"}, {31'b0, busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        err_acc;
        logic [31:0] exp_bits;
        int          st0, sp0, lat2;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_busy", {31'b0, busy}, 0);
        checkOutput("rst_done", {31'b0, done}, 0);
        checkOutput("rst_ack_error", {31'b0, ack_error}, 0);
        checkOutput("rst_data_out", {24'b0, data_out}, 0);
        checkOutput("rst_scl", {31'b0, scl_b}, 1);
        checkOutput("rst_sda", {31'b0, sda_b}, 1);

        // Write 0xA5 to 0x2A
        st0 = start_cnt;
        sp0 = stop_cnt;
        applyStimulus("wr", 1'b0, 7'h2A, 8'hA5, 1'b0, 320, err_acc);
        exp_bits = {13'b0, 7'h2A, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
        checkOutput("wr_ack_error", {31'b0, ack_error}, 0);
        checkOutput("wr_nbits", bus_nbits, 19);
        checkOutput("wr_bits", bus_bits, exp_bits);
        checkOutput("wr_slave_rx", {24'b0, s_rx}, 32'hA5);
        checkOutput("wr_starts", start_cnt - st0, 1);
        checkOutput("wr_stops", stop_cnt - sp0, 1);
        checkOutput("wr_data_out", {24'b0, data_out}, 0);

        // Read 0x3C from 0x2A
        applyStimulus("rd", 1'b1, 7'h2A, 8'h00, 1'b0, 320, err_acc);
        exp_bits = {13'b0, 7'h2A, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0};
        checkOutput("rd_data_out", {24'b0, data_out}, 32'h3C);
        checkOutput("rd_ack_error", {31'b0, ack_error}, 0);
        checkOutput("rd_nbits", bus_nbits, 19);
        checkOutput("rd_bits", bus_bits, exp_bits);

        // Address NACK: nobody at 0x11
        sp0 = stop_cnt;
        applyStimulus("nack", 1'b0, 7'h11, 8'h55, 1'b0, 176, err_acc);
        checkOutput("nack_ack_error", {31'b0, ack_error}, 1);
        checkOutput("nack_nbits", bus_nbits, 10);
        checkOutput("nack_bits", bus_bits, {22'b0, 7'h11, 1'b0, 1'b1, 1'b0});
        checkOutput("nack_data_out", {24'b0, data_out}, 32'h3C);
        checkOutput("nack_stops", stop_cnt - sp0, 1);
        repeat (5) @(negedge clk);
        checkOutput("nack_sticky", {31'b0, ack_error}, 1);

        // start held high through the whole transaction and its done cycle
        st0 = start_cnt;
        applyStimulus("hold", 1'b0, 7'h11, 8'h00, 1'b1, 176, err_acc);
        checkOutput("hold_err_cleared_on_accept", {31'b0, err_acc}, 0);
        checkOutput("hold_one_txn", start_cnt - st0, 1);
        checkOutput("hold_ack_error", {31'b0, ack_error}, 1);

        // A fresh start after done clears ack_error
        applyStimulus("again", 1'b0, 7'h2A, 8'h5A, 1'b0, 320, err_acc);
        checkOutput("again_err_cleared_on_accept", {31'b0, err_acc}, 0);
        checkOutput("again_ack_error", {31'b0, ack_error}, 0);
        checkOutput("again_slave_rx", {24'b0, s_rx}, 32'h5A);

        // Reset in the middle of a write
        @(negedge clk);
        rw = 1'b0;
        slave_addr = 7'h2A;
        data_in = 8'hC3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        checkOutput("mid_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mrst_scl", {31'b0, scl_b}, 1);
        checkOutput("mrst_sda", {31'b0, sda_b}, 1);
        checkOutput("mrst_busy", {31'b0, busy}, 0);
        checkOutput("mrst_done", {31'b0, done}, 0);
        checkOutput("mrst_data_out", {24'b0, data_out}, 0);
        applyStimulus("post", 1'b0, 7'h2A, 8'h96, 1'b0, 320, err_acc);
        checkOutput("post_ack_error", {31'b0, ack_error}, 0);
        checkOutput("post_slave_rx", {24'b0, s_rx}, 32'h96);
        checkOutput("post_bits", bus_bits, {13'b0, 7'h2A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0});

        // CLK_DIV=2 instance: address NACK transaction, 11 slots of 8 clocks
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        lat2 = 0;
        @(negedge clk);
        start2 = 1'b0;
        while (done2 !== 1'b1 && lat2 < 1000) begin
            @(posedge clk);
            lat2++;
            @(negedge clk);
        end
        checkOutput("div2_latency", lat2, 88);
        checkOutput("div2_ack_error", {31'b0, ack_error2}, 1);
        checkOutput("div2_start_edges", start2_cnt, 1);
        checkOutput("div2_stop_edges", stop2_cnt, 1);
        checkOutput("div2_high_4clk", hi_ok, 9);
        checkOutput("div2_high_other", hi_bad, 0);
        checkOutput("div2_low_4clk", lo4, 9);
        checkOutput("div2_low_other", lo_other, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_master_controller.md
Name: i2c_master_controller

Overview:
Single-byte I2C bus master (initiator) that drives SCL and SDA open-drain.
- On a start request it issues START, address+R/W, and checks the slave ACK.
- It then writes or reads one data byte and issues STOP.
- It runs off the system clock, and SCL is derived by an internal quarter-phase divider.
- It sits between register-level control logic and the shared I2C bus; slave controllers on the same bus are its counterpart.

Parameters:
ADDR_WIDTH, 7, slave address width
DATA_WIDTH, 8, data byte width
CLK_DIV, 4, system clocks per SCL quarter-period (must be >= 2); bit time = 4*CLK_DIV clocks

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset; one clock, reset sampled on rising clk
scl  inout  1  I2C clock; driven 0 or released (z), never driven 1
sda  inout  1  I2C data; driven 0 or released (z), never driven 1
start  input  1  transaction request, sampled when busy=0
rw  input  1  0 = write, 1 = read
slave_addr  input  ADDR_WIDTH  target address
data_in  input  DATA_WIDTH  byte to write
data_out  output  DATA_WIDTH  last byte read
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse at transaction end
ack_error  output  1  slave NACKed address or write data; sticky until next accepted start

Behaviour:
- Reset values: scl/sda released, data_out=0, busy=0, done=0, ack_error=0, state IDLE, divider cleared.
- Reset mid-transaction: both lines released on the next clk, no STOP is generated, and outputs return to reset values.
- Accept rule: in IDLE, start=1 latches rw, slave_addr and data_in, clears ack_error, and sets busy the next cycle.
  - start is ignored while busy=1.
  - start in the same cycle as done is ignored; a new start is accepted only from IDLE.
- Divider: quarter tick every CLK_DIV clocks; each bit slot = quarters q0..q3.
- Per bit slot:
  - q0: SCL low, SDA set (drive 0 for bit 0, release for bit 1).
  - q1: SCL low.
  - q2: SCL released.
  - q3: SCL released.
  - SDA is sampled on the last clk of q2.
- States and transitions:
  - IDLE -> START_C on accepted start.
  - START_C:
    - q0-q1: SDA and SCL released.
    - q2-q3: SDA low, SCL released.
    - -> ADDR.
  - ADDR: shifts {slave_addr, rw} MSB first, ADDR_WIDTH+1 slots, then -> ACK_ADDR.
  - ACK_ADDR: SDA released and sampled.
    - Sample 1 (NACK): ack_error=1, -> STOP_C.
    - Sample 0 and rw=0: -> WRITE_DATA.
    - Sample 0 and rw=1: -> READ_DATA.
  - WRITE_DATA: DATA_WIDTH slots, MSB first, -> ACK_DATA.
  - ACK_DATA: sample 1 sets ack_error; -> STOP_C in either case.
  - READ_DATA: SDA released; DATA_WIDTH sampled bits are shifted into a shift register MSB first, then -> MASTER_NACK.
  - MASTER_NACK: SDA released for the whole slot (end-of-read NACK); data_out is loaded from the shift register at slot start; -> STOP_C.
  - STOP_C:
    - q0: SCL low, SDA low.
    - q1: SCL released, SDA low.
    - q2-q3: both released.
    - -> IDLE; done=1 for one cycle and busy=0 in that same cycle.
- Latency (ACKed transaction): (ADDR_WIDTH+DATA_WIDTH+5)*4*CLK_DIV clocks from accept to done. With defaults this is 320 clocks; an address NACK gives 11 slots = 176 clocks.
- Bit/slot counter width: $clog2(DATA_WIDTH+1). Counter is reloaded on every state entry; no wrap-around.
- No clock stretching and no arbitration. The scl pin is not read back, and the sda pin is read only during ACK and READ slots.
- Write transactions leave data_out unchanged.

Decomposition:
- Package i2c_pkg:
  - master_state_t enum (IDLE, START_C, ADDR, ACK_ADDR, WRITE_DATA, ACK_DATA, READ_DATA, MASTER_NACK, STOP_C).
  - quarter_t enum (Q0..Q3).
  - Constants I2C_ACK=1'b0, I2C_NACK=1'b1.
- Sub-module i2c_quarter_gen:
  - Parameter CLK_DIV; ports clk, rst, en.
  - Outputs quarter (quarter_t), qtick (last clk of quarter), slot_end.

Test Plan:
1. Write: addr 7'h2A, rw=0, data_in 8'hA5, pullup plus slave model ACKing -> bus bits 0101010_0, ACK, 10100101, ACK; STOP; done after 320 clks; ack_error=0.
2. Read: addr 7'h2A, rw=1, slave returns 8'h3C -> data_out=8'h3C; SDA released in slot 19 (NACK); STOP; done at 320 clks.
3. Address NACK: addr 7'h11, no slave -> ack_error=1; no data slots; STOP; done at 176 clks; data_out unchanged.
4. start pulsed every cycle while busy -> exactly one transaction; busy is continuous; a second start after done runs a new transaction and clears ack_error.
5. rst asserted at clk 100 of a write -> next clk: scl=z, sda=z, busy=0; the next start gives a clean full transaction.
6. CLK_DIV=2 -> SCL high and low each 4 clks; START has SDA falling while SCL high; STOP has SDA rising while SCL high; SDA changes only while SCL is low.
